sd_cmd_engine: RTL and testbench

Hardware command engine for the SD card CMD line: it replaces software bit-banging of a CMD-pin PIO with a sequencer. Software writes an argument and a command index over an Avalon-MM slave port. The engine then generates the SD clock, serializes the 48-bit command frame with CRC7, waits for and deserializes the card response, and checks its CRC and end bit. It sits between the Nios system interconnect and the top-level SD_CMD tristate pad / SD_CLK pin.

---
 rtl/sd_cmd_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD card CMD-line sequencer behind an Avalon-MM slave port.
// Generates a free-running SD clock, sends 48-bit command frames with CRC7,
// then receives a response and checks its CRC7 and end bit.
// Optional feature macro: SD_CMD_R2_EN enables 136-bit R2 response capture
// (RESP2/RESP3 implemented); without it type 10 behaves as type 01.
module sd_cmd_engine #(
    parameter int CLK_DIV = 125,
    parameter int NCR_MAX = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        sd_clk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef SD_CMD_R2_EN
    localparam int RESP_W = 127;
`else
    localparam int RESP_W = 38;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick, rise_tick, fall_tick;
    logic [1:0]        sync;
    logic              cmd_in;
    logic [2:0]        state;
    logic [31:0]       arg_reg;
    logic [1:0]        resp_type;
    logic [39:0]       tx_sr;
    logic [6:0]        crc;
    logic [7:0]        cnt;
    logic [RESP_W-1:0] resp;
    logic [127:0]      resp_ext;
    logic              pend_timeout, pend_crc, pend_end;
    logic              done, timeout, crc_err, end_err;
    logic              busy, wr, cmd_start, sts_wr, finish;
    logic [3:0]        clr;
    logic              long_resp, crc_en, cap_en, cmp_en;
    logic [7:0]        rx_last;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign rise_tick = tick & ~sd_clk;
    assign fall_tick = tick & sd_clk;
    assign cmd_in    = sync[1];

    assign busy      = (state != S_IDLE);
    assign wr        = chipselect & ~write_n;
    assign cmd_start = wr && (address == 3'd1) && !busy;
    assign sts_wr    = wr && (address == 3'd2);
    assign clr       = sts_wr ? writedata[4:1] : 4'b0000;
    assign finish    = (state == S_GAP) && rise_tick && (cnt == 8'd7);
    assign irq       = done;

`ifdef SD_CMD_R2_EN
    assign long_resp = (resp_type == 2'b10);
`else
    assign long_resp = 1'b0;
`endif

    // Receive bit classification; cnt is the index of the bit after the start bit.
    assign rx_last  = long_resp ? 8'd135 : 8'd47;
    assign crc_en   = long_resp ? (cnt >= 8'd8   && cnt <= 8'd127) : (cnt >= 8'd1  && cnt <= 8'd39);
    assign cap_en   = long_resp ? (cnt >= 8'd8   && cnt <= 8'd134) : (cnt >= 8'd2  && cnt <= 8'd39);
    assign cmp_en   = long_resp ? (cnt >= 8'd128 && cnt <= 8'd134) : (cnt >= 8'd40 && cnt <= 8'd46);
    assign resp_ext = {{(128 - RESP_W){1'b0}}, resp};

    // Free-running SD clock divider.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the CMD pad input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else          sync <= {sync[0], sd_cmd_i};
    end

    // ARG register; writes while busy are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               arg_reg <= '0;
        else if (wr && address == 3'd0 && !busy)    arg_reg <= writedata;
    end

    // Transaction sequencer: send frame, wait/receive response, Ncc gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            resp_type    <= 2'b00;
            tx_sr        <= '0;
            crc          <= '0;
            cnt          <= '0;
            resp         <= '0;
            pend_timeout <= 1'b0;
            pend_crc     <= 1'b0;
            pend_end     <= 1'b0;
            sd_cmd_o     <= 1'b1;
            sd_cmd_oe    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_start) begin
                    resp_type    <= writedata[7:6];
                    tx_sr        <= {1'b0, 1'b1, writedata[5:0], arg_reg};
                    crc          <= '0;
                    cnt          <= '0;
                    resp         <= '0;
                    pend_timeout <= 1'b0;
                    pend_crc     <= 1'b0;
                    pend_end     <= 1'b0;
                    state        <= S_SEND;
                end
                S_SEND: if (fall_tick) begin
                    if (cnt < 8'd40) begin
                        sd_cmd_oe <= 1'b1;
                        sd_cmd_o  <= tx_sr[39];
                        tx_sr     <= {tx_sr[38:0], 1'b0};
                        crc       <= crc7_step(crc, tx_sr[39]);
                        cnt       <= cnt + 8'd1;
                    end else if (cnt < 8'd47) begin
                        sd_cmd_o  <= crc[6];
                        crc       <= {crc[5:0], 1'b0};
                        cnt       <= cnt + 8'd1;
                    end else if (cnt == 8'd47) begin
                        sd_cmd_o  <= 1'b1;
                        cnt       <= cnt + 8'd1;
                    end else begin
                        sd_cmd_oe <= 1'b0;
                        sd_cmd_o  <= 1'b1;
                        cnt       <= '0;
                        state     <= (resp_type == 2'b00) ? S_GAP : S_WAIT;
                    end
                end
                S_WAIT: if (rise_tick) begin
                    if (!cmd_in) begin
                        crc   <= '0;
                        cnt   <= 8'd1;
                        state <= S_RECV;
                    end else if (cnt == 8'(NCR_MAX - 1)) begin
                        pend_timeout <= 1'b1;
                        cnt          <= '0;
                        state        <= S_GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RECV: if (rise_tick) begin
                    cnt <= cnt + 8'd1;
                    if (crc_en) crc <= crc7_step(crc, cmd_in);
                    if (cmp_en) begin
                        if (cmd_in != crc[6]) pend_crc <= 1'b1;
                        crc <= {crc[5:0], 1'b0};
                    end
                    if (cap_en) resp <= {resp[RESP_W-2:0], cmd_in};
                    if (cnt == rx_last) begin
                        pend_end <= ~cmd_in;
                        cnt      <= '0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: if (rise_tick) begin
                    if (cnt == 8'd7) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // STATUS flags: cleared on start, write-1-to-clear, set at finish (set wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            crc_err <= 1'b0;
            end_err <= 1'b0;
        end else if (cmd_start) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            crc_err <= 1'b0;
            end_err <= 1'b0;
        end else begin
            done    <= (done    & ~clr[0]) | finish;
            timeout <= (timeout & ~clr[1]) | (finish & pend_timeout);
            crc_err <= (crc_err & ~clr[2]) | (finish & pend_crc & (resp_type != 2'b11));
            end_err <= (end_err & ~clr[3]) | (finish & pend_end);
        end
    end

    // Registered read mux, one cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= arg_reg;
                3'd2:    readdata <= {27'd0, end_err, crc_err, timeout, done, busy};
                3'd3:    readdata <= resp_ext[31:0];
                3'd4:    readdata <= resp_ext[63:32];
                3'd5:    readdata <= resp_ext[95:64];
                3'd6:    readdata <= resp_ext[127:96];
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: card model on the CMD line,
// frame monitor feeding a scoreboard of expected command frames.
module tb_sd_cmd_engine;

    localparam int CLK_DIV = 4;
    localparam int NCR_MAX = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq, sd_clk, sd_cmd_o, sd_cmd_oe, sd_cmd_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sd_cmd_engine #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .sd_clk(sd_clk), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
    );

    // Reference CRC7 over the low n bits of data, MSB first.
    function automatic logic [6:0] crc7(input logic [127:0] data, input int n);
        logic [6:0] c = 7'd0;
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk48(input logic tbit, input logic [5:0] idx,
                                         input logic [31:0] a, input logic crc_flip,
                                         input logic endb);
        logic [39:0] h;
        logic [6:0]  c;
        h = {1'b0, tbit, idx, a};
        c = crc7({88'd0, h}, 40) ^ {6'd0, crc_flip};
        return {h, c, endb};
    endfunction

    // Card model: answers card_len bits two SD clocks after the host frame.
    logic [135:0] card_bits = '0;
    int           card_len = 0;
    logic         card_drv = 1'b1;
    assign sd_cmd_i = sd_cmd_oe ? sd_cmd_o : card_drv;

    initial begin
        forever begin
            @(negedge sd_cmd_oe);
            if (card_len > 0 && reset_n) begin
                repeat (2) @(negedge sd_clk);
                for (int i = card_len - 1; i >= 0; i--) begin
                    card_drv = card_bits[i];
                    @(negedge sd_clk);
                end
                card_drv = 1'b1;
            end
        end
    end

    // Frame monitor and oe-fall-to-done latency counter (in SD clock rises).
    logic [47:0] exp_q[$];
    logic [47:0] act_q[$];
    int          bits_q[$];
    logic [47:0] mon_frame = '0;
    int          mon_bits = 0;
    logic        oe_prev = 1'b0;
    int          lat_cnt = 0;
    logic        lat_run = 1'b0;

    always @(posedge sd_clk) begin
        #1;
        if (sd_cmd_oe) begin
            mon_frame = {mon_frame[46:0], sd_cmd_o};
            mon_bits++;
        end else if (oe_prev) begin
            act_q.push_back(mon_frame);
            bits_q.push_back(mon_bits);
            mon_frame = '0;
            mon_bits  = 0;
            lat_cnt   = 1;
            lat_run   = 1'b1;
        end else if (lat_run) begin
            lat_cnt++;
        end
        if (lat_run && irq) lat_run = 1'b0;
        oe_prev = sd_cmd_oe;
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_irq(output logic ok);
        int n = 0;
        while (!irq && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = irq;
    endtask

    task automatic pop_tx(output logic [47:0] got, output int bits, output logic [47:0] want);
        if (act_q.size() > 0) begin
            got  = act_q.pop_front();
            bits = bits_q.pop_front();
        end else begin
            got  = 'x;
            bits = 0;
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sd_cmd_oe !== 1'b0 || sd_cmd_o !== 1'b1 || irq !== 1'b0 || sd_clk !== 1'b0 || readdata !== 32'd0)
            $display("FAIL reset_pins: oe=%b o=%b irq=%b sd_clk=%b rd=%h, want 0 1 0 0 0",
                     sd_cmd_oe, sd_cmd_o, irq, sd_clk, readdata);
        else pass_cnt++;
        reset_n = 1'b1;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'd0) $display("FAIL reset_status: got %h want 0", rd); else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'd0) $display("FAIL reset_arg: got %h want 0", rd); else pass_cnt++;
    endtask

    task automatic test_type00();
        logic [31:0] rd;
        logic [47:0] got, want;
        int          bits;
        logic        ok;
        card_len = 0;
        bus_write(3'd0, 32'd0);
        exp_q.push_back(48'h40_0000_0000_95);
        bus_write(3'd1, 32'h00);
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'h1) $display("FAIL t00_busy: got %h want 1", rd); else pass_cnt++;
        wait_irq(ok);
        total_cnt++;
        if (!ok) $display("FAIL t00_done: irq=%b want 1 within budget", irq); else pass_cnt++;
        pop_tx(got, bits, want);
        total_cnt++;
        if (got !== want || bits != 48)
            $display("FAIL t00_frame: got %h (%0d bits) want %h (48 bits)", got, bits, want);
        else pass_cnt++;
        total_cnt++;
        if (lat_cnt != 8) $display("FAIL t00_gap: got %0d SD clocks want 8", lat_cnt); else pass_cnt++;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'h2 || irq !== 1'b1)
            $display("FAIL t00_status: got %h irq=%b want 2 irq=1", rd, irq);
        else pass_cnt++;
    endtask

    // One 48-bit response transaction; checks frame, status and captured response.
    task automatic r48_case(input string name, input logic [31:0] arg, input logic [7:0] cmd,
                            input logic [47:0] tx_exp, input logic [47:0] card,
                            input logic [31:0] st_exp, input logic [31:0] r0_exp,
                            input logic [31:0] r1_exp);
        logic [31:0] rd;
        logic [47:0] got, want;
        int          bits;
        logic        ok;
        bus_write(3'd0, arg);
        card_bits = {88'd0, card};
        card_len  = 48;
        exp_q.push_back(tx_exp);
        bus_write(3'd1, {24'd0, cmd});
        wait_irq(ok);
        total_cnt++;
        if (!ok) $display("FAIL %s_done: irq=%b want 1 within budget", name, irq); else pass_cnt++;
        pop_tx(got, bits, want);
        total_cnt++;
        if (got !== want || bits != 48)
            $display("FAIL %s_frame: got %h (%0d bits) want %h (48 bits)", name, got, bits, want);
        else pass_cnt++;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== st_exp) $display("FAIL %s_status: got %h want %h", name, rd, st_exp); else pass_cnt++;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== r0_exp) $display("FAIL %s_resp0: got %h want %h", name, rd, r0_exp); else pass_cnt++;
        bus_read(3'd4, rd);
        total_cnt++;
        if (rd !== r1_exp) $display("FAIL %s_resp1: got %h want %h", name, rd, r1_exp); else pass_cnt++;
        card_len = 0;
    endtask

    task automatic test_r7();
        r48_case("r7", 32'h1AA, 8'h48, 48'h48_0000_01AA_87,
                 mk48(1'b0, 6'h08, 32'h1AA, 1'b0, 1'b1), 32'h2, 32'h1AA, 32'h08);
    endtask

    task automatic test_errors();
        r48_case("crc", 32'h1AA, 8'h48, 48'h48_0000_01AA_87,
                 mk48(1'b0, 6'h08, 32'h1AA, 1'b1, 1'b1), 32'hA, 32'h1AA, 32'h08);
        r48_case("r3", 32'h1AA, 8'hC8, 48'h48_0000_01AA_87,
                 mk48(1'b0, 6'h08, 32'h1AA, 1'b1, 1'b1), 32'h2, 32'h1AA, 32'h08);
        r48_case("endb", 32'h1AA, 8'h48, 48'h48_0000_01AA_87,
                 mk48(1'b0, 6'h08, 32'h1AA, 1'b0, 1'b0), 32'h12, 32'h1AA, 32'h08);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic [47:0] got, want;
        int          bits;
        logic        ok;
        card_len = 0;
        exp_q.push_back(48'h48_0000_01AA_87);
        bus_write(3'd1, 32'h48);
        wait_irq(ok);
        total_cnt++;
        if (!ok) $display("FAIL to_done: irq=%b want 1 within budget", irq); else pass_cnt++;
        pop_tx(got, bits, want);
        total_cnt++;
        if (got !== want || bits != 48)
            $display("FAIL to_frame: got %h (%0d bits) want %h (48 bits)", got, bits, want);
        else pass_cnt++;
        total_cnt++;
        if (lat_cnt != NCR_MAX + 8)
            $display("FAIL to_latency: got %0d SD clocks want %0d", lat_cnt, NCR_MAX + 8);
        else pass_cnt++;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'h6) $display("FAIL to_status: got %h want 6", rd); else pass_cnt++;
        bus_write(3'd2, 32'h1E);
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'h0 || irq !== 1'b0)
            $display("FAIL to_clear: got %h irq=%b want 0 irq=0", rd, irq);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_busy();
        logic [31:0] rd;
        logic [47:0] got, want;
        int          bits;
        logic        ok;
        card_len = 0;
        bus_write(3'd0, 32'h1111_1111);
        exp_q.push_back(mk48(1'b1, 6'h05, 32'h1111_1111, 1'b0, 1'b1));
        bus_write(3'd1, 32'h05);
        repeat (40) @(negedge clk);
        bus_write(3'd0, 32'h2222_2222);
        bus_write(3'd1, 32'h3F);
        wait_irq(ok);
        total_cnt++;
        if (!ok) $display("FAIL busy_done: irq=%b want 1 within budget", irq); else pass_cnt++;
        pop_tx(got, bits, want);
        total_cnt++;
        if (got !== want || bits != 48)
            $display("FAIL busy_frame: got %h (%0d bits) want %h (48 bits)", got, bits, want);
        else pass_cnt++;
        repeat (100) @(negedge clk);
        total_cnt++;
        if (act_q.size() != 0 || sd_cmd_oe !== 1'b0)
            $display("FAIL busy_extra: %0d extra frames oe=%b want 0 frames oe=0", act_q.size(), sd_cmd_oe);
        else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'h1111_1111) $display("FAIL busy_arg: got %h want 11111111", rd); else pass_cnt++;
    endtask

`ifdef SD_CMD_R2_EN
    task automatic test_r2();
        logic [119:0] payload;
        logic [127:0] content;
        logic [135:0] frame;
        logic [31:0]  rd;
        logic [31:0]  want_r[4];
        logic         ok;
        logic [47:0]  got, want;
        int           bits;
        payload   = {32'h0123_4567, 32'h89AB_CDEF, 32'h1357_9BDF, 24'h24_68AC};
        content   = {payload, crc7({8'd0, payload}, 120), 1'b1};
        frame     = {2'b00, 6'h3F, content};
        want_r[0] = content[32:1];
        want_r[1] = content[64:33];
        want_r[2] = content[96:65];
        want_r[3] = {1'b0, content[127:97]};
        bus_write(3'd0, 32'd0);
        card_bits = frame;
        card_len  = 136;
        exp_q.push_back(mk48(1'b1, 6'h02, 32'd0, 1'b0, 1'b1));
        bus_write(3'd1, 32'h82);
        wait_irq(ok);
        total_cnt++;
        if (!ok) $display("FAIL r2_done: irq=%b want 1 within budget", irq); else pass_cnt++;
        pop_tx(got, bits, want);
        total_cnt++;
        if (got !== want || bits != 48)
            $display("FAIL r2_frame: got %h (%0d bits) want %h (48 bits)", got, bits, want);
        else pass_cnt++;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'h2) $display("FAIL r2_status: got %h want 2", rd); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_read(3'(3 + i), rd);
            total_cnt++;
            if (rd !== want_r[i]) $display("FAIL r2_resp%0d: got %h want %h", i, rd, want_r[i]);
            else pass_cnt++;
        end
        card_len = 0;
    endtask
`else
    task automatic test_r2();
        logic [31:0] rd;
        r48_case("t10", 32'd0, 8'h82, mk48(1'b1, 6'h02, 32'd0, 1'b0, 1'b1),
                 mk48(1'b0, 6'h02, 32'hCAFE_F00D, 1'b1, 1'b1), 32'hA, 32'hCAFE_F00D, 32'h02);
        for (int i = 5; i < 7; i++) begin
            bus_read(3'(i), rd);
            total_cnt++;
            if (rd !== 32'd0) $display("FAIL t10_resp%0d: got %h want 0", i - 3, rd); else pass_cnt++;
        end
    endtask
`endif

    task automatic test_reset_abort();
        logic [31:0] rd;
        int          n = 0;
        card_len = 0;
        bus_write(3'd0, 32'hDEAD_BEEF);
        bus_write(3'd1, 32'h00);
        while (!sd_cmd_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (sd_cmd_oe !== 1'b1) $display("FAIL abort_start: oe=%b want 1", sd_cmd_oe); else pass_cnt++;
        repeat (80) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (sd_cmd_oe !== 1'b0 || sd_cmd_o !== 1'b1 || irq !== 1'b0)
            $display("FAIL abort_pins: oe=%b o=%b irq=%b want 0 1 0", sd_cmd_oe, sd_cmd_o, irq);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 32'd0) $display("FAIL abort_status: got %h want 0", rd); else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 32'd0) $display("FAIL abort_arg: got %h want 0", rd); else pass_cnt++;
        repeat (40) @(negedge clk);
        act_q.delete();
        bits_q.delete();
    endtask

    initial begin
        test_reset();
        test_type00();
        test_r7();
        test_errors();
        test_timeout();
        test_back_to_back_busy();
        test_r2();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
